mux_pipe_nin: RTL and testbench

Parametrised, pipelined N-input wide selector with a valid/ready handshake, the next-generation replacement for fixed 6-input 48-bit DSP-cascade selectors in the fit datapath. Each beat carries its own select, mask and mode. The block either forwards one input, or returns the modulo-2^WIDTH sum of a masked subset of inputs, which is the same add the DSP post-adder performs. It sits between the per-layer coordinate registers and the fit arithmetic, and adds backpressure and error reporting that the fixed selectors lack.

---
 rtl/mux_pipe_pkg.sv | 19 +
 rtl/mux_pipe_slice.sv | 30 +++
 rtl/mux_pipe_nin.sv | 94 +++++++++
 tb/tb_mux_pipe_nin.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pipe_pkg.sv
// Shared constants and payload layout for the pipelined N-input selector/adder.
package mux_pipe_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_SUM = 1'b1;

  localparam int DEF_WIDTH  = 48;
  localparam int DEF_NUM_IN = 6;
  localparam int DEF_SEL_W  = $clog2(DEF_NUM_IN);

  // S1 payload at the default geometry; the top declares the same field order at its own widths.
  typedef struct packed {
    logic [DEF_NUM_IN*DEF_WIDTH-1:0] data;
    logic [DEF_SEL_W-1:0]            sel;
    logic [DEF_NUM_IN-1:0]           mask;
    logic                            mode;
  } s1_payload_t;

endpackage

// File: rtl/mux_pipe_slice.sv
// Single valid/ready register slice; drains and refills in the same cycle, no skid.
module mux_pipe_slice #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic ready;

  assign ready    = !out_valid || out_ready;
  assign in_ready = reset && ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/mux_pipe_nin.sv
// Two-stage N-input selector / masked modulo adder with valid/ready and a saturating error count.
module mux_pipe_nin
  import mux_pipe_pkg::*;
#(
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int NUM_IN   = DEF_NUM_IN,
  parameter  int ERRCNT_W = 16,
  localparam int SEL_W    = $clog2(NUM_IN)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic [NUM_IN-1:0]       in_mask,
  input  logic                    in_mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ERRCNT_W-1:0]     err_count
);

  typedef struct packed {
    logic [NUM_IN*WIDTH-1:0] data;
    logic [SEL_W-1:0]        sel;
    logic [NUM_IN-1:0]       mask;
    logic                    mode;
  } payload_t;

  localparam logic [SEL_W:0] NUM_IN_W = (SEL_W+1)'(NUM_IN);

  payload_t         s1_in, s1_q;
  logic             s1_valid, s2_ready;
  logic [WIDTH-1:0] res;
  logic             err;
  logic [WIDTH:0]   s2_q;

  always_comb begin
    s1_in.data = in_data;
    s1_in.sel  = in_sel;
    s1_in.mask = in_mask;
    s1_in.mode = in_mode;
  end

  mux_pipe_slice #(.W($bits(payload_t))) u_s1 (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s1_in),
    .out_valid (s1_valid),
    .out_ready (s2_ready),
    .out_data  (s1_q)
  );

  // Out-of-range select and empty mask both yield zero data with the error flag.
  always_comb begin
    res = '0;
    err = 1'b0;
    if (s1_q.mode == MODE_SEL) begin
      err = ({1'b0, s1_q.sel} >= NUM_IN_W);
      for (int k = 0; k < NUM_IN; k++)
        if (s1_q.sel == SEL_W'(k)) res = s1_q.data[k*WIDTH +: WIDTH];
    end else begin
      err = (s1_q.mask == '0);
      for (int k = 0; k < NUM_IN; k++)
        if (s1_q.mask[k]) res = res + s1_q.data[k*WIDTH +: WIDTH];
    end
  end

  mux_pipe_slice #(.W(WIDTH+1)) u_s2 (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (s1_valid),
    .in_ready  (s2_ready),
    .in_data   ({err, res}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_q)
  );

  assign out_err  = s2_q[WIDTH];
  assign out_data = s2_q[WIDTH-1:0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      err_count <= '0;
    else if (out_valid && out_ready && out_err && (err_count != '1))
      err_count <= err_count + 1'b1;
  end

endmodule

// File: tb/tb_mux_pipe_nin.sv
// Randomised and directed bench for mux_pipe_nin against a queue-based reference model.
module tb_mux_pipe_nin;
  import mux_pipe_pkg::*;

  localparam int W = 48;
  localparam int N = 6;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [N*W-1:0] in_data = '0;
  logic [2:0]     in_sel = '0;
  logic [5:0]     in_mask = '0;
  logic           in_mode = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic           in_ready, out_valid, out_err;
  logic [W-1:0]   out_data;
  logic [15:0]    err_count;

  logic [23:0] d8 = '0;
  logic [1:0]  sel8 = '0;
  logic [2:0]  mask8 = '0;
  logic        mode8 = 1'b0, v8 = 1'b0, ordy8 = 1'b1;
  logic        rdy8, ov8, oe8;
  logic [7:0]  od8;
  logic [15:0] ec8;

  mux_pipe_nin u_dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_sel(in_sel), .in_mask(in_mask),
    .in_mode(in_mode), .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready), .err_count(err_count)
  );

  mux_pipe_nin #(.WIDTH(8), .NUM_IN(3), .ERRCNT_W(16)) u_dut8 (
    .clock(clock), .reset(reset), .in_data(d8), .in_sel(sel8), .in_mask(mask8),
    .in_mode(mode8), .in_valid(v8), .in_ready(rdy8), .out_data(od8),
    .out_err(oe8), .out_valid(ov8), .out_ready(ordy8), .err_count(ec8)
  );

  int checks = 0;
  int errors = 0;

  logic [W:0] exp_q[$];
  logic [W:0] head;
  logic       have_head, acc, cons;
  int         occ;
  int         model_err = 0;

  // Expected {err, data} straight from the functional rules.
  function automatic logic [W:0] ref_fn(input logic [N*W-1:0] d, input logic [2:0] s,
                                        input logic [5:0] m, input logic md);
    logic [63:0] sum;
    sum = '0;
    if (md == MODE_SEL) begin
      if (int'(s) >= N) return {1'b1, {W{1'b0}}};
      return {1'b0, d[s*W +: W]};
    end
    if (m == '0) return {1'b1, {W{1'b0}}};
    for (int k = 0; k < N; k++) if (m[k]) sum = sum + {16'h0, d[k*W +: W]};
    return {1'b0, sum[W-1:0]};
  endfunction

  function automatic logic [N*W-1:0] rand_data();
    logic [N*W-1:0] d;
    for (int k = 0; k < N; k++) d[k*W +: W] = {16'($urandom), $urandom()};
    return d;
  endfunction

  // One cycle: drive at negedge, sample 1 unit later, then advance the model.
  task automatic step(input logic v, input logic [N*W-1:0] d, input logic [2:0] s,
                      input logic [5:0] m, input logic md, input logic ordy);
    @(negedge clock);
    in_valid = v; in_data = d; in_sel = s; in_mask = m; in_mode = md; out_ready = ordy;
    #1;
    occ       = exp_q.size();
    have_head = (occ > 0);
    head      = have_head ? exp_q[0] : '0;
    acc       = in_valid && in_ready;
    cons      = out_valid && out_ready;
    if (cons && have_head) begin
      void'(exp_q.pop_front());
      if (head[W] && model_err < 65535) model_err++;
    end
    if (acc) exp_q.push_back(ref_fn(d, s, m, md));
  endtask

  task automatic test_reset();
    logic [N*W-1:0] d;
    reset = 1'b0; in_valid = 1'b1; in_data = rand_data(); out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock); #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || err_count !== 16'h0 || out_data !== '0 || out_err !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc %0d: in_ready=%b out_valid=%b err_count=%h out_data=%h out_err=%b, want all 0",
                 i, in_ready, out_valid, err_count, out_data, out_err);
      end
    end
    @(negedge clock);
    in_valid = 1'b0; reset = 1'b1;
    exp_q.delete(); model_err = 0;
    d = rand_data();
    step(1'b1, d, 3'd2, 6'h0, MODE_SEL, 1'b1);
    checks++;
    if (acc !== 1'b1) begin errors++; $display("FAIL reset_first_accept: got %b want 1", acc); end
    step(1'b0, d, 3'd0, 6'h0, MODE_SEL, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_lat1: out_valid %b want 0", out_valid); end
    step(1'b0, d, 3'd0, 6'h0, MODE_SEL, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || {out_err, out_data} !== {1'b0, d[143:96]}) begin
      errors++;
      $display("FAIL reset_lat2: valid=%b err=%b data=%h want 1 0 %h", out_valid, out_err, out_data, d[143:96]);
    end
  endtask

  task automatic test_select_sweep();
    logic [N*W-1:0] d;
    logic [W-1:0]   e;
    for (int k = 0; k < N; k++) d[k*W +: W] = 48'h1000_0000_0000 + 48'(k);
    for (int c = 0; c < 12; c++) begin
      step(c < 6, d, 3'(c < 6 ? c : 0), 6'h0, MODE_SEL, 1'b1);
      if (c < 6) begin
        checks++;
        if (acc !== 1'b1) begin errors++; $display("FAIL sweep_accept c=%0d: got %b want 1", c, acc); end
      end
      if (c >= 2 && c < 8) begin
        e = 48'h1000_0000_0000 + 48'(c - 2);
        checks++;
        if (out_valid !== 1'b1 || out_err !== 1'b0 || out_data !== e) begin
          errors++;
          $display("FAIL sweep_out c=%0d: valid=%b err=%b data=%h want 1 0 %h", c, out_valid, out_err, out_data, e);
        end
      end else begin
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL sweep_idle c=%0d: out_valid %b want 0", c, out_valid); end
      end
    end
  endtask

  task automatic test_masked_sum();
    logic [2:0] masks[4] = '{3'b111, 3'b101, 3'b000, 3'b010};
    logic [7:0] edat[4]  = '{8'h11, 8'hF1, 8'h00, 8'h20};
    logic       eerr[4]  = '{1'b0, 1'b0, 1'b1, 1'b0};
    d8 = {8'h01, 8'h20, 8'hF0}; mode8 = MODE_SUM; ordy8 = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clock);
      v8 = (c < 4); mask8 = masks[c < 4 ? c : 0];
      #1;
      if (c < 4) begin
        checks++;
        if (rdy8 !== 1'b1) begin errors++; $display("FAIL sum8_ready c=%0d: got %b want 1", c, rdy8); end
      end
      if (c >= 2 && c < 6) begin
        checks++;
        if (ov8 !== 1'b1 || od8 !== edat[c-2] || oe8 !== eerr[c-2]) begin
          errors++;
          $display("FAIL sum8_out c=%0d: valid=%b data=%h err=%b want 1 %h %b", c, ov8, od8, oe8, edat[c-2], eerr[c-2]);
        end
      end
      if (c == 4 || c == 6) begin
        checks++;
        if (ec8 !== ((c == 4) ? 16'd0 : 16'd1)) begin
          errors++;
          $display("FAIL sum8_errcnt c=%0d: got %0d want %0d", c, ec8, (c == 4) ? 0 : 1);
        end
      end
    end
    v8 = 1'b0;
  endtask

  task automatic test_oor();
    logic [N*W-1:0] d;
    logic [2:0]     sels[3] = '{3'd7, 3'd6, 3'd5};
    int             base;
    d = rand_data();
    base = int'(err_count);
    for (int c = 0; c < 6; c++) begin
      step(c < 3, d, sels[c < 3 ? c : 0], 6'h0, MODE_SEL, 1'b1);
      if (c >= 2 && c < 5) begin
        checks++;
        if (out_valid !== 1'b1 || {out_err, out_data} !== ((c < 4) ? {1'b1, 48'h0} : {1'b0, d[287:240]})) begin
          errors++;
          $display("FAIL oor_out c=%0d: valid=%b err=%b data=%h", c, out_valid, out_err, out_data);
        end
      end
    end
    checks++;
    if (int'(err_count) !== base + 2) begin
      errors++; $display("FAIL oor_errcnt: got %0d want %0d", err_count, base + 2);
    end
  endtask

  task automatic test_backpressure();
    logic [N*W-1:0] d;
    logic [2:0]     s;
    logic [5:0]     m;
    logic           md, pend, ordy, exp_rdy, prev_stall;
    logic [W:0]     prev;
    int             n_acc, cyc;
    pend = 1'b0; prev_stall = 1'b0; prev = '0; n_acc = 0; cyc = 0;
    d = '0; s = '0; m = '0; md = 1'b0;
    while (n_acc < 1000 && cyc < 6000) begin
      if (!pend && $urandom_range(0, 3) != 0) begin
        d = rand_data(); s = 3'($urandom_range(0, 7)); m = 6'($urandom); md = 1'($urandom); pend = 1'b1;
      end
      ordy = 1'($urandom);
      step(pend, d, s, m, md, ordy);
      exp_rdy = !(occ == 2 && !ordy);
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++; $display("FAIL bp_ready cyc %0d: got %b want %b (occ %0d)", cyc, in_ready, exp_rdy, occ);
      end
      if (out_valid) begin
        checks++;
        if (!have_head || {out_err, out_data} !== head) begin
          errors++; $display("FAIL bp_data cyc %0d: got %h want %h", cyc, {out_err, out_data}, head);
        end
      end
      if (prev_stall) begin
        checks++;
        if ({out_valid, out_err, out_data} !== {1'b1, prev}) begin
          errors++; $display("FAIL bp_hold cyc %0d: got %b/%h want 1/%h", cyc, out_valid, {out_err, out_data}, prev);
        end
      end
      prev_stall = out_valid && !ordy;
      prev = {out_err, out_data};
      if (acc) begin n_acc++; pend = 1'b0; end
      cyc++;
    end
    checks++;
    if (n_acc < 1000) begin errors++; $display("FAIL bp_timeout: accepted %0d want 1000", n_acc); end
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      step(1'b0, d, s, m, md, 1'b1);
      if (out_valid) begin
        checks++;
        if (!have_head || {out_err, out_data} !== head) begin
          errors++; $display("FAIL bp_drain: got %h want %h", {out_err, out_data}, head);
        end
      end
    end
    step(1'b0, d, s, m, md, 1'b1);
    checks++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_drain_end: left %0d valid %b want 0 0", exp_q.size(), out_valid);
    end
    checks++;
    if (int'(err_count) !== model_err) begin
      errors++; $display("FAIL bp_errcnt: got %0d want %0d", err_count, model_err);
    end
  endtask

  task automatic test_saturate();
    logic [N*W-1:0] d;
    logic [15:0]    prev_ec;
    int             bad;
    d = rand_data(); prev_ec = err_count; bad = 0;
    for (int i = 0; i < 65540; i++) begin
      step(1'b1, d, 3'd7, 6'h0, MODE_SEL, 1'b1);
      checks++;
      if (err_count < prev_ec) begin
        errors++; bad++;
        if (bad < 4) $display("FAIL sat_monotonic i=%0d: got %h after %h", i, err_count, prev_ec);
      end
      prev_ec = err_count;
    end
    for (int i = 0; i < 3; i++) step(1'b0, d, 3'd0, 6'h0, MODE_SEL, 1'b1);
    checks++;
    if (err_count !== 16'hFFFF) begin errors++; $display("FAIL sat_final: got %h want ffff", err_count); end
  endtask

  task automatic test_reset_midflight();
    logic [N*W-1:0] d1, d3;
    d1 = rand_data(); d3 = rand_data();
    step(1'b1, d1, 3'd1, 6'h0, MODE_SEL, 1'b0);
    checks++;
    if (acc !== 1'b1) begin errors++; $display("FAIL mid_acc1: got %b want 1", acc); end
    step(1'b1, d1, 3'd3, 6'h0, MODE_SEL, 1'b0);
    checks++;
    if (acc !== 1'b1) begin errors++; $display("FAIL mid_acc2: got %b want 1", acc); end
    @(negedge clock);
    reset = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || err_count !== 16'h0) begin
      errors++; $display("FAIL mid_in_reset: valid=%b ready=%b errcnt=%h want 0 0 0", out_valid, in_ready, err_count);
    end
    @(negedge clock);
    reset = 1'b1;
    exp_q.delete(); model_err = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, d1, 3'd0, 6'h0, MODE_SEL, 1'b1);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_ghost i=%0d: out_valid %b want 0", i, out_valid); end
    end
    step(1'b1, d3, 3'd4, 6'h0, MODE_SEL, 1'b1);
    checks++;
    if (acc !== 1'b1) begin errors++; $display("FAIL mid_acc3: got %b want 1", acc); end
    step(1'b0, d3, 3'd0, 6'h0, MODE_SEL, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_lat1: out_valid %b want 0", out_valid); end
    step(1'b0, d3, 3'd0, 6'h0, MODE_SEL, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || {out_err, out_data} !== {1'b0, d3[239:192]}) begin
      errors++; $display("FAIL mid_lat2: valid=%b got %h want %h", out_valid, {out_err, out_data}, {1'b0, d3[239:192]});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_select_sweep();
    test_masked_sum();
    test_oor();
    test_backpressure();
    test_saturate();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
